// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package serial_sub_pkg;

  // Controller states: wait for a request, process one bit per clock,
  // then present the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default operand / result width in bits.
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bi, with borrow out.
// Purely combinational; the serial subtractor reuses a single instance
// for every bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = a ^ b ^ bi;
  // Borrow when a < b outright, or when a == b and a borrow is pending.
  assign bo   = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = r1 - r2 - bi, one bit per
// clock, LSB first, with a start/busy/done handshake. Latency is WIDTH
// edges from the accepting edge; throughput one operation per WIDTH+2
// cycles.
// Optional feature: define SERIAL_SUB_OVF_EN to add the registered signed
// overflow output ovf (and the operand sign-capture flops it needs).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a;        // minuend, shifted right each SHIFT edge
  logic [WIDTH-1:0] b;        // subtrahend, shifted right each SHIFT edge
  logic [WIDTH-1:0] p;        // partial result, filled from the MSB end
  logic             br;       // borrow carried between bit positions
  logic [CW-1:0]    cnt;      // index of the bit being processed

  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;
  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] p_next;

  // The single shared cell always works on the current LSBs.
  full_subtractor u_cell (
    .a    (a[0]),
    .b    (b[0]),
    .bi   (br),
    .diff (cell_d),
    .bo   (cell_bo)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = (state == IDLE) && start;
  assign finish   = (state == SHIFT) && last_bit;
  // Partial result including the bit produced on this edge.
  assign p_next   = {cell_d, p[WIDTH-1:1]};

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      p      <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a     <= r1;
            b     <= r2;
            p     <= '0;
            br    <= bi;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a   <= {1'b0, a[WIDTH-1:1]};
          b   <= {1'b0, b[WIDTH-1:1]};
          p   <= p_next;
          br  <= cell_bo;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // Results change only here, so they never show partial values.
            diff   <= p_next;
            borrow <= cell_bo;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_sign;
  logic b_sign;

  // Capture operand signs at acceptance; flag signed overflow on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (accept) begin
        a_sign <= r1[WIDTH-1];
        b_sign <= r2[WIDTH-1];
      end
      if (finish) begin
        ovf <= (a_sign != b_sign) && (p_next[WIDTH-1] != a_sign);
      end
    end
  end
`else
  // accept/finish only feed the overflow logic; keep them referenced.
  logic unused_ctl;
  assign unused_ctl = accept ^ finish;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 4).
// Define SERIAL_SUB_OVF_EN for both bench and RTL to exercise ovf.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] r1;
  logic [3:0] r2;
  logic       bi;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .r1     (r1),
    .r2     (r2),
    .bi     (bi),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation; operands are scrambled right after acceptance so
  // the result must come from the captured values.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [3:0] exp_d, input logic exp_bo,
                        input logic exp_ovf);
    int lat;
    int busy_cnt;
    @(negedge clk);
    r1 = a; r2 = b; bi = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; r1 = ~a; r2 = ~b; bi = ~c;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " diff"}, diff, exp_d);
    check({tag, " borrow"}, borrow, exp_bo);
    check({tag, " busy cycles"}, busy_cnt, 5);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected unknown ovf expectation for %s", tag);
`endif
    @(posedge clk); #1;
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle done"}, done, 0);
    check({tag, " diff holds"}, diff, exp_d);
    $display("op %s: %0h - %0h - %0b -> diff=%0h borrow=%0b latency=%0d", tag, a, b, c, diff, borrow, lat);
  endtask

  initial begin
    int pulses;
    int last_edge;
    int waited;

    rst = 1'b1; start = 1'b0; r1 = '0; r2 = '0; bi = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Basic vectors (ovf expectations from the sign-bit rule).
    run_op("9-3",    4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    run_op("3-9",    4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1);
    run_op("0-0-1",  4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    run_op("F-F",    4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    run_op("8-1",    4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
    run_op("7-F",    4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
    run_op("5-2",    4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0);
    run_op("2-5-1",  4'h2, 4'h5, 1'b1, 4'hC, 1'b1, 1'b0);

    // Start held high: one done pulse every 6 cycles.
    @(negedge clk);
    r1 = 4'hC; r2 = 4'h4; bi = 1'b1; start = 1'b1;
    pulses = 0;
    last_edge = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (pulses == 0) check("held first done edge", i, 4);
        else check("held done spacing", i - last_edge, 6);
        check("held diff", diff, 4'h7);
        pulses++;
        last_edge = i;
      end
    end
    check("held pulse count", pulses, 3);
    $display("held start: %0d done pulses in 20 cycles", pulses);
    @(negedge clk); start = 1'b0;
    waited = 0;
    while (busy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("held drain", busy, 0);

    // Reset in the middle of an operation aborts it.
    run_op("9-3 pre", 4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    @(negedge clk);
    r1 = 4'h3; r2 = 4'h9; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;        // E0
    start = 1'b0;
    @(posedge clk); #1;        // E1: first SHIFT edge
    @(posedge clk);            // E2
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort diff", diff, 0);
    check("abort borrow", borrow, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort no done", done, 0);
      if (i == 2) begin
        @(negedge clk); rst = 1'b0;
      end
    end
    $display("abort: diff=%0h borrow=%0b busy=%0b", diff, borrow, busy);
    run_op("3-9 post", 4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
